alu_rr_sched: RTL and testbench



---
 rtl/alu_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_rr_sched.sv | 107 ++++++++++
 tb/tb_alu_rr_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared constants for the round-robin ALU scheduler: FSM state encodings and ALU opcodes.
package alu_sched_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_ANDN = 3'b011;
    // Any 1xx opcode selects the ALU default a | ~b; this is the canonical encoding.
    localparam logic [2:0] OP_ORN  = 3'b100;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request found upward from ptr+1,
// wrapping modulo NREQ. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic           found;
    logic [IDW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        // k runs 1..NREQ so the last grant is examined last.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (en && !found && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one registered ALU among NREQ requesters: round-robin grant in IDLE, issue the
// operands, capture the result one cycle later and return it on a tagged response channel.
module alu_rr_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_opcode,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic [2:0]        alu_opcode,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    input  logic [W-1:0]      alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data,
    output logic              busy
);

    logic [1:0]      state_q, state_d;
    logic [IDW-1:0]  ptr_q;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            arb_en;
    logic            grant;
    logic [2:0]      sel_op;
    logic [W-1:0]    sel_a, sel_b;

    // Gating with rst keeps req_ready low while reset is held, so no handshake is lost.
    assign arb_en = (state_q == IDLE) && !rst;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    assign req_ready = gnt;
    assign grant     = |gnt;
    assign busy      = (state_q != IDLE);

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                sel_op = req_opcode[3*i +: 3];
                sel_a  = req_a[W*i +: W];
                sel_b  = req_b[W*i +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= IDW'(NREQ - 1);
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                alu_opcode <= sel_op;
                alu_a      <= sel_a;
                alu_b      <= sel_b;
                rsp_id     <= gnt_idx;
                ptr_q      <= gnt_idx;
            end
            if (state_q == WAIT) begin
                rsp_data  <= alu_result;
                rsp_valid <= 1'b1;
            end
            if (state_q == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched with a registered ALU model and a response scoreboard.
module tb_alu_rr_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_opcode;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic [2:0]        alu_opcode;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [W-1:0]      alu_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;
    logic              busy;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    alu_rr_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opcode(req_opcode),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_opcode(alu_opcode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_result(alu_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return a & ~b;
            default: return a | ~b;
        endcase
    endfunction

    // External ALU: one-cycle registered result.
    always @(posedge clk) alu_result <= alu_f(alu_opcode, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && req_valid[i])
                    sb.push_back(exp_t'({2'(i), alu_f(req_opcode[3*i +: 3], req_a[W*i +: W],
                                                       req_b[W*i +: W])}));
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b);
        req_opcode[3*i +: 3] = op;
        req_a[W*i +: W]      = a;
        req_b[W*i +: W]      = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for a grant; returns its index and cycle, then steps past the accept edge.
    task automatic wait_grant(output int idx, output int at);
        idx = -1;
        at  = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
                at = cyc;
                break;
            end
        end
        if (idx < 0) check("grant_timeout", 32'd0, 32'd1);
        step();
    endtask

    task automatic drain();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("drain_busy", 32'(busy), 32'd0);
        step();
    endtask

    initial begin
        int idx, at, prev_at;
        logic [7:0] t2_exp [4];
        logic [2:0] t2_op  [4];
        int         t3_ord [6];
        t2_op  = '{3'b001, 3'b010, 3'b011, 3'b111};
        t2_exp = '{8'hFC, 8'hCC, 8'hC0, 8'hF3};
        t3_ord = '{0, 1, 2, 3, 0, 1};

        rst = 1'b1;
        req_valid = '0;
        req_opcode = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        set_req(0, 3'b000, 8'hF0, 8'h3C);
        req_valid = 4'b0001;
        repeat (3) step();

        // Reset state, with a request pending that must not be accepted.
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu", {alu_opcode, alu_a, alu_b}, 32'd0);
        check("rst_rsp", {rsp_id, rsp_data}, 32'd0);
        step();
        rst = 1'b0;

        // Test 1: first IDLE cycle grants req0; response three cycles later.
        @(negedge clk);
        check("t1_ready_first", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("t1_busy", 32'(busy), 32'd1);
            check("t1_rsp_valid", 32'(rsp_valid), (k == 3) ? 32'd1 : 32'd0);
        end
        check("t1_rsp_id", 32'(rsp_id), 32'd0);
        check("t1_rsp_data", 32'(rsp_data), 32'h30);
        step();
        rsp_ready = 1'b1;
        drain();

        // Test 2: one requester, back-to-back ops every 4 cycles.
        prev_at = 0;
        req_valid = 4'b0001;
        for (int j = 0; j < 4; j++) begin
            set_req(0, t2_op[j], 8'hF0, 8'h3C);
            wait_grant(idx, at);
            check("t2_idx", idx, 32'd0);
            if (j > 0) check("t2_spacing", at - prev_at, 32'd4);
            prev_at = at;
            if (j == 3) req_valid = '0;
            repeat (3) @(negedge clk);
            check("t2_rsp_data", 32'(rsp_data), 32'(t2_exp[j]));
        end
        drain();

        // Test 3: all four requesting, round-robin order from a fresh reset.
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        set_req(0, 3'b000, 8'h5A, 8'h3C);
        set_req(1, 3'b001, 8'hC3, 8'h96);
        set_req(2, 3'b010, 8'h0F, 8'hF0);
        set_req(3, 3'b110, 8'h81, 8'h24);
        req_valid = 4'b1111;
        for (int j = 0; j < 6; j++) begin
            wait_grant(idx, at);
            check("t3_order", idx, t3_ord[j]);
        end
        req_valid = '0;
        drain();

        // Test 4: consumer stalls 5 cycles in RESP.
        rsp_ready = 1'b0;
        req_valid = 4'b1100;
        wait_grant(idx, at);
        check("t4_idx", idx, 32'd2);
        req_valid = 4'b1000;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(rsp_valid), 32'd1);
            check("t4_hold_data", 32'(rsp_data), 32'(alu_f(3'b010, 8'h0F, 8'hF0)));
            check("t4_hold_id", 32'(rsp_id), 32'd2);
            check("t4_no_ready", 32'(req_ready), 32'd0);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        check("t4_next_grant", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        drain();

        // Test 5: reset during WAIT discards the operation and the pointer.
        req_valid = 4'b0100;
        wait_grant(idx, at);
        check("t5_idx", idx, 32'd2);
        req_valid = '0;
        step();
        rst = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_no_rsp", 32'(rsp_valid), 32'd0);
            check("t5_busy", 32'(busy), 32'd0);
        end
        check("t5_alu_zero", {alu_opcode, alu_a, alu_b}, 32'd0);
        step();
        req_valid = 4'b1001;
        wait_grant(idx, at);
        check("t5_after_rst", idx, 32'd0);
        req_valid = '0;
        drain();

        // Test 6: wrap-around from pointer 3 to index 1.
        req_valid = 4'b1000;
        wait_grant(idx, at);
        check("t6_first", idx, 32'd3);
        req_valid = 4'b1010;
        wait_grant(idx, at);
        check("t6_second", idx, 32'd1);
        req_valid = '0;
        drain();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
